cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and Main_memory.
- Holds tag, valid and 4-word data arrays internally; sequences Main_memory block reads on a miss and single-word writes on a store.
- Keeps read hit and read miss statistics for performance runs.

Parameters:
- ADDR_W, 15, word address width (matches the memory address)
- WORD_W, 32, data word width
- INDEX_W, 8, cache index bits (256 lines x 4 words = 1024 words)
- MEM_LATENCY, 2, cycles mem_read_en is held before read_data_128 is sampled (must be >=1)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_address  in  ADDR_W  word address of the request
- cpu_write_data  in  WORD_W  store data
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_ready  out  1  high only in IDLE; a request is accepted when (cpu_read|cpu_write) & cpu_ready
- cpu_done  out  1  one-cycle completion pulse
- cpu_read_data  out  WORD_W  load result; valid while cpu_done=1, held until the next load completes
- mem_address  out  ADDR_W  memory address (block-aligned for reads: low 2 bits = 0)
- mem_write_data  out  WORD_W  memory store data
- mem_read_en  out  1  memory block read enable
- mem_write_en  out  1  memory word write enable
- mem_read_data_128  in  4*WORD_W  block from memory; word k at bits [32k+31:32k]
- hit_count  out  CNT_W  read hits, saturating
- miss_count  out  CNT_W  read misses, saturating

Behaviour:
- Address split: offset = addr[1:0], index = addr[INDEX_W+1:2], tag = the remaining upper bits.
- Reset (rst=0, async): state IDLE; all valid bits 0; cpu_done, mem_read_en, mem_write_en = 0; cpu_read_data, mem_address, mem_write_data, hit_count, miss_count = 0; cpu_ready = 1. The data and tag arrays need no reset.
- Reset mid-operation aborts the transaction with no cpu_done. Lines filled before reset are invalid afterwards.
- The request is latched on acceptance in cycle 0. The CPU inputs are don't-care afterwards.
- cpu_read and cpu_write both high: treated as a load; the store is dropped.
- FSM states: IDLE, COMPARE, MEM_READ, FILL, MEM_WRITE, RESP.
  - IDLE -> COMPARE on accept.
  - COMPARE (cycle 1), load hit (valid & tag match): capture the word, hit_count+1, go to RESP.
  - COMPARE, load miss: miss_count+1, go to MEM_READ.
  - COMPARE, store: go to MEM_WRITE. If the store hits, the cached word is updated in this cycle. A store miss leaves the cache unchanged.
  - MEM_READ: mem_read_en=1 and mem_address={addr[ADDR_W-1:2],2'b00}, held stable for exactly MEM_LATENCY cycles (down-counter). The block is sampled on the last cycle; then go to FILL.
  - FILL: write the data line, write the tag, set valid, select the word by offset into cpu_read_data; go to RESP.
  - MEM_WRITE: mem_write_en=1 for exactly one cycle, with mem_address=full addr and mem_write_data=store data; go to RESP.
  - RESP: cpu_done=1 for one cycle; go to IDLE. cpu_ready rises the following cycle.
- cpu_done latency, counting from the accept cycle as 0:
  - load hit: cycle 2
  - load miss: cycle MEM_LATENCY+3
  - store: cycle 3
- mem_read_en and mem_write_en are never both high. Both are 0 outside MEM_READ and MEM_WRITE.
- Counters saturate at all-ones and never wrap. Stores are not counted.
- Eviction needs no write-back (write-through). A conflicting fill overwrites the tag and data.

Decomposition:
- Package cache_pkg holds:
  - the state enum
  - address-field widths and derived localparams for TAG_W and the line width
  - address-split helper functions
- Sub-module cache_store: tag, valid and data arrays with one synchronous write port and combinational lookup. It takes a clear_valid input that rst drives.
- The FSM, latency counter and statistics stay in cache_controller.

Test Plan:
- Memory preloaded with word i = i for i in 1024..9215. Reset, then load 1025 -> miss; cpu_done at cycle MEM_LATENCY+3, cpu_read_data=1025; mem_address=1024 with mem_read_en high for MEM_LATENCY cycles; miss_count=1.
- Then load 1026 -> hit; cpu_done at cycle 2, data=1026; mem_read_en stays 0; hit_count=1.
- Store 0x0000ABCD to 1025 -> one mem_write_en cycle at address 1025. A following load of 1025 hits with data 0x0000ABCD and no memory read.
- Store 0x55 to 3000 (not cached) -> memory is written; a following load of 3000 misses and returns 0x55.
- Conflict: load 1025 (hit), then load 2049 (same index, different tag) -> miss returning 2049. Then load 1025 -> miss again.
- Assert rst=0 during MEM_READ of load 4000 -> outputs return to reset values immediately with no cpu_done. Then load 1026 -> miss, because valid bits were cleared.
- With CNT_W=2, perform 5 load hits -> hit_count stays at 3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, address-field widths and helpers for the
// direct-mapped write-through cache controller.
package cache_pkg;

    localparam int ADDR_W_DEF  = 15;
    localparam int WORD_W_DEF  = 32;
    localparam int INDEX_W_DEF = 8;
    localparam int OFF_W       = 2;
    localparam int WORDS       = 1 << OFF_W;
    localparam int TAG_W       = ADDR_W_DEF - INDEX_W_DEF - OFF_W;
    localparam int LINE_W      = WORDS * WORD_W_DEF;

    typedef logic [ADDR_W_DEF-1:0]  addr_t;
    typedef logic [INDEX_W_DEF-1:0] index_t;
    typedef logic [TAG_W-1:0]       tag_t;
    typedef logic [OFF_W-1:0]       off_t;
    typedef logic [WORD_W_DEF-1:0]  word_t;
    typedef logic [LINE_W-1:0]      line_t;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MEM_READ,
        FILL,
        MEM_WRITE,
        RESP
    } state_e;

    function automatic off_t addr_off(addr_t a);
        return a[OFF_W-1:0];
    endfunction

    function automatic index_t addr_index(addr_t a);
        return a[INDEX_W_DEF+OFF_W-1:OFF_W];
    endfunction

    function automatic tag_t addr_tag(addr_t a);
        return a[ADDR_W_DEF-1:INDEX_W_DEF+OFF_W];
    endfunction

    function automatic word_t line_word(line_t l, off_t o);
        return l[o*WORD_W_DEF +: WORD_W_DEF];
    endfunction

    function automatic line_t line_put(line_t l, off_t o, word_t w);
        line_t r;
        r = l;
        r[o*WORD_W_DEF +: WORD_W_DEF] = w;
        return r;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU load/store port plus main-memory port and statistics of the cache.
interface cache_controller_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0]   cpu_address;
    logic [WORD_W-1:0]   cpu_write_data;
    logic                cpu_read;
    logic                cpu_write;
    logic                cpu_ready;
    logic                cpu_done;
    logic [WORD_W-1:0]   cpu_read_data;
    logic [ADDR_W-1:0]   mem_address;
    logic [WORD_W-1:0]   mem_write_data;
    logic                mem_read_en;
    logic                mem_write_en;
    logic [4*WORD_W-1:0] mem_read_data_128;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    miss_count;

    modport master (
        output cpu_address, cpu_write_data, cpu_read, cpu_write,
        output mem_read_data_128,
        input  cpu_ready, cpu_done, cpu_read_data,
        input  mem_address, mem_write_data, mem_read_en, mem_write_en,
        input  hit_count, miss_count
    );

    modport slave (
        input  cpu_address, cpu_write_data, cpu_read, cpu_write,
        input  mem_read_data_128,
        output cpu_ready, cpu_done, cpu_read_data,
        output mem_address, mem_write_data, mem_read_en, mem_write_en,
        output hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller_store.sv
// Tag, valid and data arrays: one synchronous write port, async lookup.
// clear_valid is active low and invalidates every line immediately.
module cache_store #(
    parameter int INDEX_W = cache_pkg::INDEX_W_DEF,
    parameter int TAG_W   = cache_pkg::TAG_W,
    parameter int LINE_W  = cache_pkg::LINE_W
) (
    input  logic               clk,
    input  logic               clear_valid,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);
    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_index] = 1'b1;
    end

    always_ff @(posedge clk or negedge clear_valid) begin
        if (!clear_valid) valid_q <= '0;
        else              valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller
// with saturating read hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WORD_W      = WORD_W_DEF,
    parameter int INDEX_W     = INDEX_W_DEF,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              load_q, load_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    line_t             line_q, line_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    logic              st_valid;
    tag_t              st_tag;
    line_t             st_line;
    logic              wr_en;
    line_t             wr_line;
    logic              hit;
    logic              accept;
    index_t            idx;
    off_t              off;

    assign idx    = addr_index(addr_q);
    assign off    = addr_off(addr_q);
    assign hit    = st_valid && (st_tag == addr_tag(addr_q));
    assign accept = (bus.cpu_read || bus.cpu_write) && (state_q == IDLE);

    cache_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .LINE_W  (LINE_W)
    ) u_store (
        .clk         (clk),
        .clear_valid (rst),
        .rd_index    (idx),
        .rd_valid    (st_valid),
        .rd_tag      (st_tag),
        .rd_line     (st_line),
        .wr_en       (wr_en),
        .wr_index    (idx),
        .wr_tag      (addr_tag(addr_q)),
        .wr_line     (wr_line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            load_q  <= 1'b0;
            lat_q   <= '0;
            line_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            load_q  <= load_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        load_d  = load_q;
        lat_d   = lat_q;
        line_d  = line_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        wr_en   = 1'b0;
        wr_line = st_line;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.cpu_address;
                    wdata_d = bus.cpu_write_data;
                    load_d  = bus.cpu_read;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (load_q && hit) begin
                    rdata_d = line_word(st_line, off);
                    if (!(&hit_q)) hit_d = hit_q + 1'b1;
                    state_d = RESP;
                end else if (load_q) begin
                    if (!(&miss_q)) miss_d = miss_q + 1'b1;
                    lat_d   = LAT_W'(MEM_LATENCY - 1);
                    state_d = MEM_READ;
                end else begin
                    // write-through: refresh the cached word only on a hit
                    wr_en   = hit;
                    wr_line = line_put(st_line, off, wdata_q);
                    state_d = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (lat_q == '0) begin
                    line_d  = bus.mem_read_data_128;
                    state_d = FILL;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            FILL: begin
                wr_en   = 1'b1;
                wr_line = line_q;
                rdata_d = line_word(line_q, off);
                state_d = RESP;
            end
            MEM_WRITE: state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_ready      = 1'b0;
        bus.cpu_done       = 1'b0;
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        unique case (state_q)
            IDLE: bus.cpu_ready = 1'b1;
            MEM_READ: begin
                bus.mem_read_en = 1'b1;
                bus.mem_address = {addr_q[ADDR_W-1:2], 2'b00};
            end
            MEM_WRITE: begin
                bus.mem_write_en   = 1'b1;
                bus.mem_address    = addr_q;
                bus.mem_write_data = wdata_q;
            end
            RESP:    bus.cpu_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.cpu_read_data = rdata_q;
    assign bus.hit_count     = hit_q;
    assign bus.miss_count    = miss_q;
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: two instances (16-bit and 2-bit counters)
// share stimulus and a memory image; a set-level model predicts results.
module tb_cache_controller;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if #(.ADDR_W(15), .WORD_W(32), .CNT_W(16)) ifa ();
    cache_controller_if #(.ADDR_W(15), .WORD_W(32), .CNT_W(2))  ifb ();

    cache_controller #(.MEM_LATENCY(LAT), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    cache_controller #(.MEM_LATENCY(LAT), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    logic [14:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_rd;
    logic        c_wr;

    assign ifa.cpu_address    = c_addr;
    assign ifa.cpu_write_data = c_wdata;
    assign ifa.cpu_read       = c_rd;
    assign ifa.cpu_write      = c_wr;
    assign ifb.cpu_address    = c_addr;
    assign ifb.cpu_write_data = c_wdata;
    assign ifb.cpu_read       = c_rd;
    assign ifb.cpu_write      = c_wr;

    // main memory shared by both instances (they issue identical writes)
    logic [31:0] mem [0:32767];

    function automatic logic [127:0] blk(input logic [14:0] a);
        logic [14:0] b;
        b = {a[14:2], 2'b00};
        return {mem[b + 15'd3], mem[b + 15'd2], mem[b + 15'd1], mem[b]};
    endfunction

    always @(posedge clk)
        if (ifa.mem_write_en) mem[ifa.mem_address] <= ifa.mem_write_data;

    always @(negedge clk) begin
        ifa.mem_read_data_128 <= blk(ifa.mem_address);
        ifb.mem_read_data_128 <= blk(ifb.mem_address);
    end

    // reference model: line-presence table, memory image, hit/miss totals
    bit          m_valid [256];
    logic [4:0]  m_tag   [256];
    logic [31:0] ref_mem [0:32767];
    int          hits;
    int          misses;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ifa.cpu_ready, 1);
        check({tag, "_done"}, ifa.cpu_done, 0);
        check({tag, "_rden"}, ifa.mem_read_en, 0);
        check({tag, "_wren"}, ifa.mem_write_en, 0);
        check({tag, "_rdata"}, ifa.cpu_read_data, 0);
        check({tag, "_maddr"}, ifa.mem_address, 0);
        check({tag, "_mwdata"}, ifa.mem_write_data, 0);
        check({tag, "_hits"}, ifa.hit_count, 0);
        check({tag, "_misses"}, ifa.miss_count, 0);
        check({tag, "_b_hits"}, ifb.hit_count, 0);
    endtask

    task automatic req(input bit rd, input bit wr, input logic [14:0] a,
                       input logic [31:0] d);
        int          cyc;
        int          rd_cyc;
        int          wr_cyc;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        bit          bus_ok;
        bit          is_hit;
        logic [7:0]  idx;
        logic [4:0]  tg;
        logic [31:0] exp_data;

        idx = a[9:2];
        tg  = a[14:10];
        @(negedge clk);
        check("ready_before_req", ifa.cpu_ready, 1);
        c_rd    = rd;
        c_wr    = wr;
        c_addr  = a;
        c_wdata = d;
        @(posedge clk);
        #1;
        c_rd    = 1'b0;
        c_wr    = 1'b0;
        c_addr  = 15'($urandom);
        c_wdata = $urandom;

        cyc    = 0;
        rd_cyc = 0;
        wr_cyc = 0;
        bus_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ifa.mem_read_en) begin
                rd_cyc++;
                if (ifa.mem_address !== {a[14:2], 2'b00}) bus_ok = 1'b0;
            end
            if (ifa.mem_write_en) begin
                wr_cyc++;
                if (ifa.mem_address !== a || ifa.mem_write_data !== d)
                    bus_ok = 1'b0;
            end
            if (ifa.mem_read_en && ifa.mem_write_en) bus_ok = 1'b0;
            if (ifa.cpu_done) begin
                cyc = k;
                break;
            end
        end

        exp_data = '0;
        if (rd) begin
            is_hit = m_valid[idx] && (m_tag[idx] == tg);
            if (is_hit) begin
                hits++;
            end else begin
                misses++;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
            exp_data = ref_mem[a];
            exp_lat  = is_hit ? 2 : LAT + 3;
            exp_rd   = is_hit ? 0 : LAT;
            exp_wr   = 0;
        end else begin
            ref_mem[a] = d;
            exp_lat    = 3;
            exp_rd     = 0;
            exp_wr     = 1;
        end

        check("done_latency", cyc, exp_lat);
        check("mem_read_cycles", rd_cyc, exp_rd);
        check("mem_write_cycles", wr_cyc, exp_wr);
        check("mem_bus_values", bus_ok, 1);
        if (rd) begin
            check("read_data", ifa.cpu_read_data, exp_data);
            check("read_data_b", ifb.cpu_read_data, exp_data);
        end
        check("hit_count", ifa.hit_count, hits);
        check("miss_count", ifa.miss_count, misses);
        check("hit_count_sat", ifb.hit_count, sat3(hits));
        check("miss_count_sat", ifb.miss_count, sat3(misses));
    endtask

    initial begin
        int          r;
        logic [14:0] ra;
        logic [31:0] rdat;

        c_rd    = 1'b0;
        c_wr    = 1'b0;
        c_addr  = '0;
        c_wdata = '0;
        hits    = 0;
        misses  = 0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = (i >= 1024 && i <= 9215) ? 32'(i) : 32'd0;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        req(1, 0, 15'd1025, 32'd0);
        check("first_load_value", ifa.cpu_read_data, 1025);
        req(1, 0, 15'd1026, 32'd0);
        check("hit_value", ifa.cpu_read_data, 1026);
        req(0, 1, 15'd1025, 32'h0000ABCD);
        req(1, 0, 15'd1025, 32'd0);
        check("store_hit_value", ifa.cpu_read_data, 32'h0000ABCD);
        req(0, 1, 15'd3000, 32'h55);
        req(1, 0, 15'd3000, 32'd0);
        check("store_miss_value", ifa.cpu_read_data, 32'h55);
        req(1, 0, 15'd1025, 32'd0);
        req(1, 0, 15'd2049, 32'd0);
        check("conflict_value", ifa.cpu_read_data, 2049);
        req(1, 0, 15'd1025, 32'd0);
        req(1, 1, 15'd2050, 32'hDEAD_BEEF);
        check("rd_wr_is_load", ifa.cpu_read_data, 2050);

        // abort a line fill with reset
        @(negedge clk);
        c_rd   = 1'b1;
        c_addr = 15'd4000;
        @(posedge clk);
        #1;
        c_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_mem_read", ifa.mem_read_en, 1);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        hits   = 0;
        misses = 0;
        @(negedge clk);
        check("midreset_no_done", ifa.cpu_done, 0);
        rst = 1'b1;
        req(1, 0, 15'd1026, 32'd0);
        check("after_reset_value", ifa.cpu_read_data, 1026);

        for (int n = 0; n < 60; n++) begin
            r    = $urandom_range(0, 9);
            ra   = 15'(1024 + ($urandom_range(0, 3) << 10) + $urandom_range(0, 15));
            rdat = $urandom;
            if (r < 6)      req(1, 0, ra, rdat);
            else if (r < 9) req(0, 1, ra, rdat);
            else            req(1, 1, ra, rdat);
        end

        req(1, 0, 15'd5000, 32'd0);
        for (int n = 0; n < 5; n++) req(1, 0, 15'd5001, 32'd0);
        check("sat_hit_count", ifb.hit_count, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
